// File: rtl/hue_filter_core.sv
// -----------------------------------------------------------------------------
// hue_filter_core
//   Pixel-stream front end for the rover vision pipeline. Generates raster
//   coordinates for the frame source. Converts each incoming 8-bit RGB pixel to
//   a fixed-point hue (degrees * 2^FIXED). Then sums an N x N window of hue
//   values, using N-1 line buffers that each hold one row.
//
// Ports
//   clk       sole clock, all state updates on the rising edge
//   rst       asynchronous, active-low reset
//   r, g, b   8-bit colour components of the pixel at the current (x, y)
//   x, y      current raster column / row
//   hue       registered hue of the pixel sampled on the previous edge
//   data_out  registered, zero-extended sum of the N x N hue window
// -----------------------------------------------------------------------------
module hue_filter_core #(
  parameter int N          = 3,
  parameter int FIXED      = 4,
  parameter int PRECISION  = 16,
  parameter int DATA_WIDTH = 26,
  parameter int LINE_WIDTH = 640,
  parameter int ROW_NUMBER = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            r,
  input  logic [7:0]            g,
  input  logic [7:0]            b,
  output logic [15:0]           x,
  output logic [15:0]           y,
  output logic [PRECISION-1:0]  hue,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int PTR_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;

  // Hue constants in degrees * 2^FIXED.
  localparam int HUE_60  = 60  * (2 ** FIXED);
  localparam int HUE_120 = 120 * (2 ** FIXED);
  localparam int HUE_240 = 240 * (2 ** FIXED);
  localparam int HUE_360 = 360 * (2 ** FIXED);

  // ---------------------------------------------------------------------------
  // Raster counter
  // ---------------------------------------------------------------------------
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;

  always_comb begin
    x_d = x_q + 16'd1;
    y_d = y_q;
    if (x_q == 16'(LINE_WIDTH - 1)) begin
      x_d = '0;
      y_d = (y_q == 16'(ROW_NUMBER - 1)) ? '0 : y_q + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // ---------------------------------------------------------------------------
  // RGB -> hue (combinational, registered below)
  // ---------------------------------------------------------------------------
  logic [7:0]              max_c, min_c, delta_c;
  logic signed [9:0]       diff_c;
  logic signed [31:0]      offset_c, num_c, den_c, quot_c, hue_s_c;
  logic [PRECISION-1:0]    hue_d, hue_q;

  // NOTE: every variable gets a default at the top of an always_comb block,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    max_c    = r;
    min_c    = r;
    diff_c   = '0;
    offset_c = '0;
    if (g > max_c) max_c = g;
    if (b > max_c) max_c = b;
    if (g < min_c) min_c = g;
    if (b < min_c) min_c = b;
    delta_c = max_c - min_c;

    // Red wins ties, then green.
    if (max_c == r) begin
      diff_c   = $signed({2'b00, g}) - $signed({2'b00, b});
      offset_c = '0;
    end else if (max_c == g) begin
      diff_c   = $signed({2'b00, b}) - $signed({2'b00, r});
      offset_c = HUE_120;
    end else begin
      diff_c   = $signed({2'b00, r}) - $signed({2'b00, g});
      offset_c = HUE_240;
    end

    num_c = HUE_60 * diff_c;
    // The divisor is forced to 1 for grey pixels; that quotient is discarded.
    den_c = (delta_c == 8'd0) ? 32'sd1 : $signed({24'd0, delta_c});
    // Signed division truncates toward zero.
    quot_c  = num_c / den_c;
    hue_s_c = quot_c + offset_c;
    if (hue_s_c < 0) hue_s_c = hue_s_c + HUE_360;
    if (delta_c == 8'd0) hue_s_c = '0;

    hue_d = PRECISION'(hue_s_c);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hue_q <= '0;
    else      hue_q <= hue_d;
  end

  // ---------------------------------------------------------------------------
  // Line buffers: a chain of N-1 rows sharing one circular pointer. Buffer i
  // presents the hue from (i+1) rows ago at the pointer position.
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0]     ptr_q;
  logic [PRECISION-1:0] lb_q [N-1][LINE_WIDTH];

  // NOTE: the line buffers are cleared on reset, unlike a typical RAM. A
  // restarted frame must see zeros, not stale rows, so they are built from
  // resettable flops rather than a memory macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
      for (int i = 0; i < N - 1; i++) begin
        for (int j = 0; j < LINE_WIDTH; j++) begin
          lb_q[i][j] <= '0;
        end
      end
    end else begin
      ptr_q <= (ptr_q == PTR_W'(LINE_WIDTH - 1)) ? '0 : ptr_q + 1'b1;
      lb_q[0][ptr_q] <= hue_q;
      for (int i = 1; i < N - 1; i++) begin
        lb_q[i][ptr_q] <= lb_q[i-1][ptr_q];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // N x N window: column 0 takes the newest column, and older columns shift
  // right by one each cycle.
  // Row 0 is the current row, and row i comes from i rows earlier.
  // ---------------------------------------------------------------------------
  logic [PRECISION-1:0]  col_c [N];
  logic [PRECISION-1:0]  win_q [N][N];
  logic [DATA_WIDTH-1:0] sum_c, data_q;

  always_comb begin
    col_c[0] = hue_q;
    for (int i = 1; i < N; i++) begin
      col_c[i] = lb_q[i-1][ptr_q];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        win_q[i][0] <= col_c[i];
        for (int j = 1; j < N; j++) begin
          win_q[i][j] <= win_q[i][j-1];
        end
      end
    end
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        sum_c = sum_c + DATA_WIDTH'(win_q[i][j]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data_q <= '0;
    else      data_q <= sum_c;
  end

  assign x        = x_q;
  assign y        = y_q;
  assign hue      = hue_q;
  assign data_out = data_q;

endmodule

// File: tb/tb_hue_filter_core.sv
// -----------------------------------------------------------------------------
// tb_hue_filter_core
//   Self-checking bench for hue_filter_core. A behavioural model keeps the
//   whole hue stream since the last reset. It predicts the raster position,
//   the hue and the window sum from that history on every cycle. The frame
//   height is reduced so that frame wraps happen within a short run. The line
//   width keeps its default value.
// -----------------------------------------------------------------------------
module tb_hue_filter_core;

  localparam int N   = 3;
  localparam int FX  = 4;
  localparam int PR  = 16;
  localparam int DW  = 26;
  localparam int LW  = 640;
  localparam int RN  = 8;

  logic          clk;
  logic          rst;
  logic [7:0]    r, g, b;
  logic [15:0]   x, y;
  logic [PR-1:0] hue;
  logic [DW-1:0] data_out;

  hue_filter_core #(
    .N(N), .FIXED(FX), .PRECISION(PR), .DATA_WIDTH(DW),
    .LINE_WIDTH(LW), .ROW_NUMBER(RN)
  ) dut (
    .clk(clk), .rst(rst), .r(r), .g(g), .b(b),
    .x(x), .y(y), .hue(hue), .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int hist[$];   // expected hue per pixel index since reset release

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Hue in degrees * 2^FX. Each colour sector is 60 degrees wide and starts
  // at 0, 120 or 240 degrees. The position inside a sector is truncated
  // toward zero, and a negative result wraps around the circle.
  function automatic int ref_hue(input int rr, input int gg, input int bb);
    int mx, mn, d, a, c, base, n, q;
    mx = (rr >= gg && rr >= bb) ? rr : ((gg >= bb) ? gg : bb);
    mn = (rr <= gg && rr <= bb) ? rr : ((gg <= bb) ? gg : bb);
    d  = mx - mn;
    if (d == 0) return 0;
    if (mx == rr)      begin a = gg; c = bb; base = 0;   end
    else if (mx == gg) begin a = bb; c = rr; base = 120; end
    else               begin a = rr; c = gg; base = 240; end
    n = 60 * (1 << FX) * (a - c);
    q = (n >= 0) ? (n / d) : -((-n) / d);
    q = base * (1 << FX) + q;
    if (q < 0) q += 360 * (1 << FX);
    return q;
  endfunction

  // Sum of the N x N neighbourhood ending at pixel index 'newest' in the
  // linear stream. Pixels before the start of the stream count as 0.
  function automatic int ref_window(input int newest);
    int s;
    s = 0;
    for (int rr = 0; rr < N; rr++) begin
      for (int cc = 0; cc < N; cc++) begin
        int j;
        j = newest - cc - rr * LW;
        if (j >= 0) s += hist[j];
      end
    end
    return s;
  endfunction

  function automatic logic [23:0] rand_px();
    logic [7:0] a, c, e;
    a = 8'($urandom_range(0, 255));
    c = 8'($urandom_range(0, 255));
    e = 8'($urandom_range(0, 255));
    case ($urandom_range(0, 5))
      0: return {a, a, a};
      1: return {a, a, e};
      2: return {a, c, a};
      3: return {a, c, c};
      default: return {a, c, e};
    endcase
  endfunction

  // One pixel: drive the colour, take one edge, then compare every output
  // with the model at the following falling edge.
  task automatic step(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
    int m, cnt;
    r = rr; g = gg; b = bb;
    @(posedge clk);
    hist.push_back(ref_hue(rr, gg, bb));
    @(negedge clk);
    m   = hist.size() - 1;
    cnt = m + 1;
    check("x", 32'(x), 32'(cnt % LW));
    check("y", 32'(y), 32'((cnt / LW) % RN));
    check("hue", 32'(hue), 32'(hist[m]));
    check("data_out", 32'(data_out), 32'(ref_window(m - 2)));
  endtask

  task automatic step_rand();
    logic [23:0] p;
    p = rand_px();
    step(p[23:16], p[15:8], p[7:0]);
  endtask

  // Entered just after a falling edge. Reset is asynchronous, so the outputs
  // must already be zero at the next falling edge.
  task automatic apply_reset(input int cycles);
    logic [23:0] p;
    rst = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      p = rand_px();
      r = p[23:16]; g = p[15:8]; b = p[7:0];
      @(negedge clk);
      check("rst_x", 32'(x), 32'd0);
      check("rst_y", 32'(y), 32'd0);
      check("rst_hue", 32'(hue), 32'd0);
      check("rst_data", 32'(data_out), 32'd0);
    end
    rst = 1'b1;
    hist.delete();
  endtask

  initial begin
    int hits, others;
    rst = 1'b0;
    r = '0; g = '0; b = '0;
    @(negedge clk);
    apply_reset(3);

    // Primary and fractional hues.
    step(8'd255, 8'd0,   8'd0);   check("hue_red",     32'(hue), 32'd0);
    step(8'd0,   8'd255, 8'd0);   check("hue_green",   32'(hue), 32'd1920);
    step(8'd0,   8'd0,   8'd255); check("hue_blue",    32'(hue), 32'd3840);
    step(8'd255, 8'd0,   8'd255); check("hue_magenta", 32'(hue), 32'd4800);
    step(8'd100, 8'd100, 8'd100); check("hue_grey",    32'(hue), 32'd0);
    step(8'd255, 8'd128, 8'd0);   check("hue_orange",  32'(hue), 32'd481);
    for (int i = 0; i < 40; i++) step_rand();

    // Window fill with a constant green field.
    apply_reset(2);
    for (int i = 0; i < (N - 1) * LW + N + 4; i++) step(8'd0, 8'd255, 8'd0);
    check("fill_steady", 32'(data_out), 32'd17280);

    // Single blue impulse in a zero field.
    apply_reset(2);
    hits = 0; others = 0;
    for (int i = 0; i < N * LW + 20; i++) begin
      if (i == 5) step(8'd0, 8'd0, 8'd255);
      else        step(8'd0, 8'd0, 8'd0);
      if (data_out == DW'(3840)) hits++;
      else if (data_out != '0)  others++;
    end
    check("impulse_hits", 32'(hits), 32'(N * N));
    check("impulse_other", 32'(others), 32'd0);

    // Random stream across a full frame wrap, then a mid-frame reset.
    apply_reset(2);
    for (int i = 0; i < LW * RN + 50; i++) step_rand();
    for (int i = 0; i < 700; i++) step_rand();
    apply_reset(2);
    for (int i = 0; i < 2 * LW + 100; i++) step_rand();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
